ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 153 +++++++++++++++
 tb/tb_ram_burst_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive words out of a dual-port RAM read port onto a
// valid/ready interface with a registered output stage and a done pulse.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  read_en_o,
    output logic [ADDR_WIDTH-1:0] read_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int                MEM_SIZE   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MEM_SIZE_L = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH:0] REM_ONE    = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;

    logic [ADDR_WIDTH:0]     eff_len;
    logic                    start_accept;
    logic                    read_en;
    logic                    busy;
    logic                    xfer;
    logic                    final_xfer;

    // Requests longer than the RAM are clipped so every word is read at most once.
    assign eff_len      = (length_i > MEM_SIZE_L) ? MEM_SIZE_L : length_i;
    assign start_accept = (state_q == IDLE) && start_i;
    assign xfer         = valid_q && ready_i;
    assign final_xfer   = xfer && last_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would create
    // order-dependent simulation and mismatch synthesis.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && (eff_len != '0)) state_d = READ;
            READ:    if (final_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        read_en = 1'b0;
        if (state_q == READ) begin
            busy    = 1'b1;
            // Fetch only when the output register is empty or draining this edge.
            read_en = (remaining_q != '0) && (!valid_q || ready_i);
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;

        if (start_accept) begin
            ptr_d       = base_addr_i;
            remaining_d = eff_len;
            if (eff_len == '0) begin
                done_d = 1'b1;
            end
        end

        if (read_en) begin
            ptr_d       = ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            data_d      = mem_data_i;
            valid_d     = 1'b1;
            last_d      = (remaining_q == REM_ONE);
        end else if (xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (final_xfer) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign read_en_o   = read_en;
    assign read_addr_o = ptr_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign busy_o      = busy;
    assign done_o      = done_q;

    // A stalled word must not change under the consumer.
    a_stall_hold : assert property (@(posedge clk) disable iff (rst)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(last_o)));

    a_idle_quiet : assert property (@(posedge clk) disable iff (rst)
        !busy_o |-> (!valid_o && !read_en_o));

    a_done_idle : assert property (@(posedge clk) disable iff (rst)
        done_o |-> !busy_o);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: bursts push expected words, a negedge
// monitor pops and compares on every transfer and checks stall stability.
module tb_ram_burst_reader;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int MEM = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   length_i = '0;
    logic          ready_i = 1'b1;
    logic          read_en_o;
    logic [AW-1:0] read_addr_o;
    logic [DW-1:0] mem_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    logic [DW-1:0] mem [MEM];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t   sb[$];
    beat_t   exp_beat;
    int      checks_total  = 0;
    int      checks_passed = 0;
    int      done_cnt      = 0;
    int      pop_cnt       = 0;
    logic    stall_mode    = 1'b0;
    int      ready_idx     = 0;
    logic    prev_stall    = 1'b0;
    logic [DW-1:0] prev_data;
    logic    prev_last;

    ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .read_en_o   (read_en_o),
        .read_addr_o (read_addr_o),
        .mem_data_i  (mem_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial begin
        for (int i = 0; i < MEM; i++) mem[i] = DW'(i + 100);
    end
    assign mem_data_i = mem[read_addr_o];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready pattern 1,0,0,... while stalling; otherwise always ready.
    always @(posedge clk) begin
        #2;
        if (stall_mode) begin
            ready_i = (ready_idx % 3 == 0);
            ready_idx++;
        end else begin
            ready_i = 1'b1;
        end
    end

    // Monitor: a transfer happens at the next rising edge when these hold now.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall valid held", valid_o, 1);
            check("stall data held", data_o, prev_data);
            check("stall last held", last_o, prev_last);
        end
        if (valid_o === 1'b1 && ready_i === 1'b1 && rst === 1'b0) begin
            if (sb.size() == 0) begin
                checks_total++;
                $display("FAIL spurious word: got data %0d, expected no word", data_o);
            end else begin
                exp_beat = sb.pop_front();
                check("word data", data_o, exp_beat.data);
                check("word last", last_o, exp_beat.last);
                pop_cnt++;
            end
        end
        if (done_o === 1'b1) done_cnt++;
        prev_stall = (valid_o === 1'b1 && ready_i === 1'b0 && rst === 1'b0);
        prev_data  = data_o;
        prev_last  = last_o;
    end

    task automatic issue(input int base, input int len);
        int eff;
        eff = (len > MEM) ? MEM : len;
        for (int i = 0; i < eff; i++) begin
            beat_t b;
            b.data = DW'((base + i) % MEM + 100);
            b.last = (i == eff - 1);
            sb.push_back(b);
        end
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        length_i    = (AW + 1)'(len);
        tick();
        start_i     = 1'b0;
        base_addr_i = ~base_addr_i;
        length_i    = (AW + 1)'(1);
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (done_o !== 1'b1 && lat < 3000) begin
            tick();
            lat++;
        end
        if (done_o !== 1'b1) check({name, " done timeout"}, done_o, 1);
    endtask

    task automatic run_burst(input string name, input int base, input int len, input int exp_lat);
        int d0, p0, lat, eff;
        d0  = done_cnt;
        p0  = pop_cnt;
        eff = (len > MEM) ? MEM : len;
        issue(base, len);
        if (len == 0) check({name, " busy stays low"}, busy_o, 0);
        wait_done(name, lat);
        if (exp_lat >= 0) check({name, " latency"}, lat, exp_lat);
        check({name, " queue drained"}, sb.size(), 0);
        check({name, " word count"}, pop_cnt - p0, eff);
        tick();
        check({name, " done single pulse"}, done_o, 0);
        check({name, " done count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, p0, lat;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("reset valid", valid_o, 0);
        check("reset last", last_o, 0);
        check("reset done", done_o, 0);
        check("reset busy", busy_o, 0);
        check("reset data", data_o, 0);
        check("reset read_en", read_en_o, 0);
        rst = 1'b0;
        tick();

        run_burst("basic", 5, 4, 5);
        run_burst("wrap", 1022, 4, 5);

        stall_mode = 1'b1;
        tick();
        run_burst("stall", 20, 3, -1);
        stall_mode = 1'b0;
        tick();

        run_burst("zero length", 300, 0, 0);
        run_burst("saturate", 7, 2000, 1025);

        // Reset after two of eight words have transferred.
        d0 = done_cnt;
        p0 = pop_cnt;
        issue(30, 8);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort words before reset", pop_cnt - p0, 2);
        check("abort valid", valid_o, 0);
        check("abort busy", busy_o, 0);
        check("abort read_en", read_en_o, 0);
        sb.delete();
        tick();
        tick();
        check("abort no done", done_cnt - d0, 0);
        run_burst("after abort", 40, 2, 3);

        // Back-to-back: second start issued in the done cycle of the first.
        d0 = done_cnt;
        p0 = pop_cnt;
        issue(50, 3);
        wait_done("b2b first", lat);
        check("b2b first latency", lat, 4);
        issue(60, 2);
        wait_done("b2b second", lat);
        check("b2b second latency", lat, 3);
        check("b2b queue drained", sb.size(), 0);
        tick();
        check("b2b done count", done_cnt - d0, 2);
        check("b2b word count", pop_cnt - p0, 5);

        // Start pulsed mid-burst is ignored.
        d0 = done_cnt;
        p0 = pop_cnt;
        issue(70, 4);
        tick();
        start_i     = 1'b1;
        base_addr_i = AW'(900);
        length_i    = (AW + 1)'(5);
        tick();
        start_i = 1'b0;
        wait_done("mid start", lat);
        check("mid start latency", lat + 2, 5);
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("mid start word count", pop_cnt - p0, 4);
        check("mid start done count", done_cnt - d0, 1);
        check("mid start idle", busy_o, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
